// File: rtl/coin_acceptor.sv
// coin_acceptor
//
// Front end for the vending machine FSM. Synchronizes and debounces the two
// raw coin sensors, then emits one single-cycle coin code per physical coin
// (01 = 1 unit, 10 = 2 units). Inhibited insertions and insertions where both
// sensors are active emit a single-cycle reject pulse instead.
//
// Optional feature macro: COIN_JAM_DETECT_EN
//   defined   : a sensor held high too long after acceptance latches a sticky
//               jam fault; all sensors are ignored until reset.
//   undefined : no jam logic; jam is tied low and release is awaited forever.
//
// Parameters
//   DB_CYCLES  consecutive stable samples to accept a press/release (2..255)
//   JAM_CYCLES high samples in REL before jam (DB_CYCLES+1 .. 2^CNT_W-1)
//   CNT_W      width of the debounce/jam counters
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset
//   s1    in   raw 1-unit sensor (asynchronous)
//   s2    in   raw 2-unit sensor (asynchronous)
//   inh   in   inhibit, sampled at the accept edge (synchronous to clk)
//   coin  out  registered one-cycle coin code
//   rej   out  registered one-cycle reject pulse
//   jam   out  sticky jam flag
//
// Handshake: coin/rej are unqualified one-cycle strobes; the consumer must
// act on them in the cycle they are high, there is no backpressure.
//
// The FSM state is held in the named signal "state" so checkers can be bound
// to it directly.

module coin_acceptor #(
  parameter int DB_CYCLES  = 4,
  parameter int JAM_CYCLES = 1000,
  parameter int CNT_W      = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s1,
  input  logic       s2,
  input  logic       inh,
  output logic [1:0] coin,
  output logic       rej,
  output logic       jam
);

  // Elaboration-time guard on the legal parameter ranges.
  if (DB_CYCLES < 2 || DB_CYCLES > 255 || JAM_CYCLES <= DB_CYCLES ||
      JAM_CYCLES > (2 ** CNT_W) - 1) begin : g_param_check
    $error("coin_acceptor: illegal DB_CYCLES/JAM_CYCLES/CNT_W combination");
  end

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEB,
    REL
`ifdef COIN_JAM_DETECT_EN
    ,
    JAM
`endif
  } state_t;

  state_t state;

  // Two-flop synchronizers; only q1/q2 are seen by the FSM.
  logic s1_meta, s2_meta;
  logic q1, q2;
  logic [1:0] pat;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_meta <= 1'b0;
      s2_meta <= 1'b0;
      q1      <= 1'b0;
      q2      <= 1'b0;
    end else begin
      s1_meta <= s1;
      s2_meta <= s2;
      q1      <= s1_meta;
      q2      <= s2_meta;
    end
  end

  assign pat = {q2, q1};

  // cnt counts press samples in DEB and consecutive zero samples in REL.
  logic [CNT_W-1:0] cnt;
  logic [1:0]       typ;

`ifdef COIN_JAM_DETECT_EN
  localparam logic [CNT_W-1:0] JAM_LAST = CNT_W'(JAM_CYCLES - 1);
  // High-time counter in REL; JAM is entered on the JAM_CYCLES-th high
  // sample, so it never needs to count past JAM_LAST.
  logic [CNT_W-1:0] hcnt;
`else
  assign jam = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      typ   <= 2'b00;
      coin  <= 2'b00;
      rej   <= 1'b0;
`ifdef COIN_JAM_DETECT_EN
      hcnt  <= '0;
      jam   <= 1'b0;
`endif
    end else begin
      // Outputs are strobes: cleared every cycle unless an accept fires.
      coin <= 2'b00;
      rej  <= 1'b0;
      case (state)
        IDLE: begin
          if (pat != 2'b00) begin
            state <= DEB;
            typ   <= pat;
            cnt   <= CNT_W'(1);
          end
        end

        DEB: begin
          if (pat != typ) begin
            // Any change (drop, or a second sensor joining) restarts; IDLE
            // re-latches the new pattern on its next sample.
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= REL;
            cnt   <= '0;
`ifdef COIN_JAM_DETECT_EN
            hcnt  <= '0;
`endif
            if (inh || typ == 2'b11) begin
              rej <= 1'b1;
            end else begin
              coin <= typ;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        REL: begin
          if (pat == 2'b00) begin
            if (cnt == DB_LAST) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            cnt <= '0;
`ifdef COIN_JAM_DETECT_EN
            if (hcnt == JAM_LAST) begin
              state <= JAM;
              jam   <= 1'b1;
            end else begin
              hcnt <= hcnt + CNT_W'(1);
            end
`endif
          end
        end

`ifdef COIN_JAM_DETECT_EN
        JAM: begin
          // Sensors ignored; only reset leaves this state.
          state <= JAM;
        end
`endif

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor (DB_CYCLES = 4, JAM_CYCLES = 20).
// A monitor compares every nonzero {rej, coin} strobe against an expected
// queue filled by the stimulus code; explicit timing and reset checks are
// made inline. All comparisons go through check().

module tb_coin_acceptor;

  localparam int DB  = 4;
  localparam int JAM = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s1 = 1'b0, s2 = 1'b0, inh = 1'b0;
  logic [1:0] coin;
  logic rej, jam;

  always #5 clk = ~clk;

  coin_acceptor #(.DB_CYCLES(DB), .JAM_CYCLES(JAM), .CNT_W(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .s1   (s1),
    .s2   (s2),
    .inh  (inh),
    .coin (coin),
    .rej  (rej),
    .jam  (jam)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];   // expected {rej, coin} strobes in order

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every cycle with a nonzero strobe must match the next queued event.
  always @(negedge clk) begin
    if (!rst && (coin != 2'b00 || rej)) begin
      if (exp_q.size() > 0) check("pulse", {29'd0, rej, coin}, {29'd0, exp_q.pop_front()});
      else                  check("unexpected_pulse", {29'd0, rej, coin}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [1:0] p, input int hold, input int gap);
    @(negedge clk);
    {s2, s1} = p;
    repeat (hold) @(negedge clk);
    {s2, s1} = 2'b00;
    repeat (gap) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_coin", {30'd0, coin}, 32'd0);
    check("reset_rej",  {31'd0, rej},  32'd0);
    check("reset_jam",  {31'd0, jam},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // 1-unit coin with exact timing: capture at edge 0, pulse edges 5..6.
    exp_q.push_back(3'b001);
    s1 = 1'b1;
    @(posedge clk);                 // edge 0
    repeat (4) @(posedge clk);      // edges 1..4
    #1 check("t1_before", {30'd0, coin}, 32'd0);
    @(posedge clk);                 // edge 5
    #1 check("t1_coin", {30'd0, coin}, 32'd1);
    check("t1_rej", {31'd0, rej}, 32'd0);
    @(posedge clk);                 // edge 6
    #1 check("t1_after", {30'd0, coin}, 32'd0);
    repeat (4) @(negedge clk);
    s1 = 1'b0;
    idle(10);

    // 2-unit coin.
    exp_q.push_back(3'b010);
    press(2'b10, 10, 8);

    // 1+1+2 then 2+2 with 8 idle cycles between.
    exp_q.push_back(3'b001); press(2'b01, 10, 8);
    exp_q.push_back(3'b001); press(2'b01, 10, 8);
    exp_q.push_back(3'b010); press(2'b10, 10, 8);
    exp_q.push_back(3'b010); press(2'b10, 10, 8);
    exp_q.push_back(3'b010); press(2'b10, 10, 8);

    // Glitch: two samples only, nothing expected.
    press(2'b01, 2, 10);
    check("glitch_drained", exp_q.size(), 32'd0);

    // Both sensors together -> reject.
    exp_q.push_back(3'b100);
    press(2'b11, 10, 8);

    // Inhibited 1-unit coin -> reject.
    exp_q.push_back(3'b100);
    inh = 1'b1;
    press(2'b01, 10, 0);
    inh = 1'b0;
    idle(8);

    // Reset at the 3rd FSM sample (edge 4) of an s2 press; released with it.
    s2 = 1'b1;
    @(posedge clk);                 // edge 0 capture
    repeat (3) @(posedge clk);      // edges 1..3
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);                 // edge 4: reset sampled
    #1 check("rst_mid_coin", {30'd0, coin}, 32'd0);
    check("rst_mid_rej", {31'd0, rej}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    s2  = 1'b0;
    idle(12);
    check("rst_mid_drained", exp_q.size(), 32'd0);
    exp_q.push_back(3'b010);
    press(2'b10, 10, 8);

`ifdef COIN_JAM_DETECT_EN
    // Held 40 cycles: one 01 pulse, then jam.
    exp_q.push_back(3'b001);
    press(2'b01, 40, 4);
    check("jam_set", {31'd0, jam}, 32'd1);
    press(2'b10, 10, 8);            // ignored while jammed
    check("jam_held", {31'd0, jam}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("jam_cleared", {31'd0, jam}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);
`else
    // Without jam detection a long hold just waits for release.
    exp_q.push_back(3'b001);
    press(2'b01, 40, 8);
    check("no_jam", {31'd0, jam}, 32'd0);
    exp_q.push_back(3'b010);
    press(2'b10, 10, 8);
    check("no_jam_after", {31'd0, jam}, 32'd0);
`endif

    idle(4);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
